// File: rtl/ps2_command_tx.sv
// ps2_command_tx: PS/2 host-to-device command transmitter.
// Sends one byte (start, 8 data LSB first, odd parity, stop) and checks
// the device ACK. The pads are driven only through open-collector enables.
// Optional watchdog on missing device clocks: define PS2_CMD_TIMEOUT_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | both lines released, cmd_ready high
// INHIBIT | clock held low; data pulled low just before clock release
// REQ     | clock released, start bit on data, waiting first device clock
// SHIFT   | data, parity, stop driven on device clock falling edges
// ACK     | waiting for the ACK clock, then sample the data line
// RECOVER | waiting for clock and data both idle-high
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       timeout
);

  localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 2;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_DAT  = INH_W'(INHIBIT_CYCLES - 2);

  if (INHIBIT_CYCLES < 3 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ps2_command_tx: INHIBIT_CYCLES must be >= 3 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    REQ     = 3'd2,
    SHIFT   = 3'd3,
    ACK     = 3'd4,
    RECOVER = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       clk_sync, dat_sync;
  logic             clk_prev;
  logic             clk_s, dat_s, fe;
  logic [INH_W-1:0] inh_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       byte_q;
  logic             parity_q;
  logic             dat_oe_q;
  logic             done_q, ack_error_q;
  logic             accept;
  logic             wd_expire;

  // Two-stage synchronisers on both pads plus a delayed clock copy for edge detect
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_sync[1];
    end
  end

  assign clk_s  = clk_sync[1];
  assign dat_s  = dat_sync[1];
  assign fe     = clk_prev & ~clk_s;
  assign accept = cmd_valid & cmd_ready;

`ifdef PS2_CMD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;
  logic            timeout_q;

  assign wd_active = (state == REQ) || (state == SHIFT) ||
                     (state == ACK) || (state == RECOVER);
  assign wd_expire = wd_active && (wd_cnt == WD_LAST);

  // Watchdog: restarts on every device clock edge and on every state change
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_expire;
      if (!wd_active || fe || (state_nx != state))
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = INHIBIT;
      INHIBIT: if (inh_cnt == INH_LAST) state_nx = REQ;
      REQ:     if (fe) state_nx = SHIFT;
      SHIFT:   if (fe && (bit_cnt == 4'd9)) state_nx = ACK;
      ACK:     if (fe) state_nx = RECOVER;
      RECOVER: if (clk_s && dat_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (wd_expire)
      state_nx = IDLE;
  end

  // Datapath: byte latch, counters, data-line enable and result pulses
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      inh_cnt     <= '0;
      bit_cnt     <= '0;
      byte_q      <= '0;
      parity_q    <= 1'b0;
      dat_oe_q    <= 1'b0;
      done_q      <= 1'b0;
      ack_error_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      ack_error_q <= 1'b0;
      case (state)
        IDLE: begin
          inh_cnt  <= '0;
          bit_cnt  <= '0;
          dat_oe_q <= 1'b0;
          if (accept) begin
            byte_q   <= cmd_data;
            parity_q <= ~^cmd_data;
          end
        end
        INHIBIT: begin
          inh_cnt <= inh_cnt + INH_W'(1);
          // data goes low one cycle before the clock is released
          if (inh_cnt == INH_DAT)
            dat_oe_q <= 1'b1;
        end
        REQ: begin
          bit_cnt  <= '0;
          dat_oe_q <= 1'b1;
        end
        SHIFT: begin
          if (fe) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt <= 4'd7)
              dat_oe_q <= ~byte_q[bit_cnt[2:0]];
            else if (bit_cnt == 4'd8)
              dat_oe_q <= ~parity_q;
            else
              dat_oe_q <= 1'b0;
          end
        end
        ACK: begin
          if (fe && !wd_expire) begin
            done_q      <= ~dat_s;
            ack_error_q <= dat_s;
          end
        end
        default: begin
        end
      endcase
      if (wd_expire)
        dat_oe_q <= 1'b0;
    end
  end

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign ps2_clk_oe = (state == INHIBIT);
  assign ps2_dat_oe = dat_oe_q;
  assign done       = done_q;
  assign ack_error  = ack_error_q;

endmodule

// File: doc/ps2_command_tx.md
Name: ps2_command_tx

Overview:
- PS/2 host-to-device transmitter. It sends one command byte (for example 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard.
- It is the opposite direction of the existing PS/2 receive path.
- It sits beside the PS/2 receiver in the DE2 top level and drives the shared PS2_CLK/PS2_DAT lines through open-collector enables.
- While it is busy, the top level gates the receiver using the busy output.

Parameters:
- INHIBIT_CYCLES, 6000: CLOCK_50 cycles the clock line is held low before the request (120 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: watchdog limit between device clock edges (20 ms). Used only when PS2_CMD_TIMEOUT_EN is defined.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- cmd_data  in  8  command byte to send
- cmd_valid  in  1  request; accepted when cmd_valid && cmd_ready
- cmd_ready  out  1  high only in IDLE
- ps2_clk_in  in  1  raw PS2_CLK pad value (asynchronous)
- ps2_dat_in  in  1  raw PS2_DAT pad value (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS2_CLK low; the top level drives 1'bz otherwise
- ps2_dat_oe  out  1  1 = pull PS2_DAT low
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: byte sent and device ACK received (data sampled low)
- ack_error  out  1  one-cycle pulse: data sampled high at the ACK clock
- timeout  out  1  one-cycle pulse from the watchdog; stays 0 when the feature is compiled out

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, ack_error=0, timeout=0, cmd_ready=1.
  - State goes to IDLE; counters clear; the latched byte clears.
  - Both lines are released at once, so the device sees an aborted frame.
- Synchronisation and edge detect:
  - ps2_clk_in and ps2_dat_in each pass through a 2-FF synchroniser.
  - A falling edge (fe) is a 1-cycle pulse when the synchronised clock goes from 1 to 0.
  - Edge detection is about 3 cycles behind the pad.
- Accept:
  - In IDLE, cmd_valid && cmd_ready latches cmd_data and odd parity, parity = ~^cmd_data.
  - The FSM moves to INHIBIT on the next edge.
  - cmd_valid while busy is ignored; it is not queued.
- States:
  - IDLE: both oe = 0.
  - INHIBIT: ps2_clk_oe=1. Counter runs 0..INHIBIT_CYCLES-1. ps2_dat_oe rises at count INHIBIT_CYCLES-2, so data is low one cycle before the clock is released. At the final count, go to REQ.
  - REQ: ps2_clk_oe=0, ps2_dat_oe=1 (start bit). Bit counter n=0. Wait for fe.
  - SHIFT: on each fe, n is incremented and the data line is updated in the same cycle:
    - n=1..8: ps2_dat_oe = ~cmd_data[n-1] (LSB first).
    - n=9: ps2_dat_oe = ~parity.
    - n=10: ps2_dat_oe=0 (stop bit, line released). Go to ACK.
  - ACK: on the next fe, sample synchronised data. If 0, pulse done; if 1, pulse ack_error. Go to RECOVER.
  - RECOVER: wait until synchronised clock and data are both 1, then go to IDLE.
- ps2_clk_oe is never asserted outside INHIBIT.
- Data changes only on an fe cycle, and never while the device holds clock high mid-bit.
- done and ack_error are mutually exclusive and last exactly one cycle.
- Falling edges seen in IDLE (device-to-host traffic) are ignored.
- A simultaneous reset and fe: reset wins.

Optional Feature:
- Macro: PS2_CMD_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in REQ, SHIFT, ACK and RECOVER. It clears on every fe and on state entry.
  - When it reaches TIMEOUT_CYCLES-1, both oe are released in the same cycle, timeout pulses for one cycle, and the FSM goes to IDLE.
  - done and ack_error are not asserted for that frame.
- Not defined:
  - There is no watchdog logic; the FSM waits indefinitely for device clocks.
  - The timeout output is tied to 0.
  - Only reset_n recovers a missing device.

Test Plan:
- Send 0xED to a bench device model (~12.5 kHz clock, ACK low):
  - ps2_clk_oe is high for exactly 6000 cycles.
  - Device samples start=0, bits 1,0,1,1,0,1,1,1 (LSB first), parity=1, stop=1.
  - done pulses once; cmd_ready returns to 1 after the lines go idle.
- Send 0x07: device samples parity=0. Send 0xFF: parity=1. Send 0x00: parity=1. done pulses for each.
- Device model drives ACK high (no ACK): ack_error pulses exactly once, done stays 0, FSM returns to IDLE.
- Assert cmd_valid with 0x55 while busy during the 0xED frame: it is ignored, only 0xED is received, and cmd_ready is 0 throughout.
- Deassert reset_n after the 4th data bit: ps2_clk_oe and ps2_dat_oe go to 0 asynchronously; after release, a new 0xF4 command completes with done.
- With PS2_CMD_TIMEOUT_EN defined and the device model never clocking: timeout pulses 1000000 cycles after entering REQ, and both oe are 0. With the macro undefined: busy stays 1 and timeout stays 0.
